uart_tx_queue: RTL and testbench
================================

# uart_tx_queue

Transmit-side byte queue placed directly upstream of the UART transmitter. It accepts bytes from the host at one byte per clock, buffers them in a FIFO, and issues one `start` pulse per byte to the UART. The byte is held stable on the UART `i_data` for the whole frame, and the block paces itself on the UART's `o_busy`. Its outputs connect straight to the UART `start` / `i_data` inputs; the UART's `o_busy` connects to this block's `tx_busy` input.

## Interface
- `DEPTH`, default 16: FIFO entries; power of two, ≥ 2.
- `START_TIMEOUT`, default 8: cycles to wait for `tx_busy` to rise after `tx_start`; range 2..255.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst_n` input, 1 bit: reset, asynchronous assert, active-low.
- `wr_en` input, 1 bit: host write strobe.
- `wr_data` input, 8 bits: host byte.
- `full` output, 1 bit: FIFO holds `DEPTH` entries.
- `empty` output, 1 bit: FIFO holds 0 entries.
- `level` output, $clog2(DEPTH)+1 bits: current entry count.
- `tx_start` output, 1 bit: one-cycle launch pulse to the UART `start`.
- `tx_data` output, 8 bits: byte to the UART `i_data`; stable from the `tx_start` cycle until the frame ends.
- `tx_busy` input, 1 bit: the UART `o_busy`.
- `idle` output, 1 bit: FSM is in IDLE and the FIFO is empty.

## Operation
- **FIFO:** circular buffer with read and write pointers of log2(DEPTH) bits that wrap modulo DEPTH. `level` is a separate counter.
- **Writes:**
  - A write is accepted when `wr_en` is high and `full` is low, with `full` sampled from the current-cycle state.
  - A write while full is dropped, even if a pop happens in the same cycle.
  - A simultaneous accepted write and pop leaves `level` unchanged.
  - Writing into an empty FIFO while a pop is evaluated in the same cycle is impossible by construction, because a pop requires `!empty`.
- **FSM states:** IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
  - **IDLE:** when `!empty && !tx_busy`, pop the head into the `tx_data` register, drive `tx_start` to 1, and go to LAUNCH.
  - **LAUNCH:** drive `tx_start` back to 0, clear the timeout counter, and go to WAIT_BUSY.
  - **WAIT_BUSY:**
    - When `tx_busy` is 1, go to WAIT_DONE.
    - Otherwise increment the counter.
    - When the counter reaches `START_TIMEOUT`, re-issue `tx_start` with the same `tx_data`, with no new pop, and go to LAUNCH.
  - **WAIT_DONE:** when `tx_busy` is 0, go to IDLE.
- **`tx_data`:** changes only on a pop. Its reset value is 0x00.

## Timing
- **Reset values:**
  - `full` = 0, `empty` = 1, `level` = 0.
  - `tx_start` = 0, `tx_data` = 0x00.
  - `idle` = 1, FSM = IDLE, pointers = 0.
- **Latency:** a write is sampled at edge E into an empty, idle queue with `tx_busy` low. Then `tx_start` is 1 from edge E+1 to edge E+2, and `tx_data` equals the written byte from edge E+1.
- **Back-to-back frames:** the next `tx_start` comes no earlier than 1 cycle after `tx_busy` falls, i.e. IDLE is re-entered, then launch.
- **Pulse width:** `tx_start` is never high for two consecutive cycles.
- **`tx_busy` high in IDLE:** no launch, for example after a reset mid-frame.
- **Reset mid-frame:**
  - The FIFO is flushed and the FSM returns to IDLE.
  - The UART frame already in flight completes untouched.
  - The next launch waits for `tx_busy` low.
- **Flags:** `full`, `empty` and `level` are registered and reflect state after the edge.

## Configuration
- **With `UART_TX_QUEUE_OVERFLOW_EN` defined:**
  - Adds output `overflow` (1 bit, reset 0) and input `overflow_clr` (1 bit).
  - `overflow` is set at the edge after any dropped write and stays set until `overflow_clr` is high at an edge.
  - Set has priority over clear in the same cycle.
- **Without it:** neither port exists, and dropped writes are silent.

## Structure
- **Package `uart_pkg`:**
  - FSM state enum `txq_state_t` (IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE).
  - Byte width constant `UART_DATA_W = 8`.
  - Default `START_TIMEOUT` constant.
- **Sub-module `uart_sync_fifo`:** the parameterised storage, pointers and level. The queue FSM instantiates it.
- **Verification bench:** loops `tx_start`/`tx_data` through the existing UART with the TX-to-RX loopback and checks received bytes in order.

## Test plan
- **Single byte:** after reset, write 0xA5 once → one `tx_start` pulse at E+1, `tx_data` = 0xA5 throughout the frame, loopback receives 0xA5, `idle` returns to 1.
- **Burst:** write 0x01..0x10 (DEPTH = 16) on consecutive cycles → `full` = 1 after the 16th write when the queue is idle and no pop has occurred yet. All 16 bytes are received in order, with exactly 16 `tx_start` pulses.
- **Overflow:** with the FIFO full, write 0xFF → dropped, `level` stays 16, 0xFF is never transmitted. With `UART_TX_QUEUE_OVERFLOW_EN`, `overflow` = 1 until `overflow_clr` is pulsed.
- **Start timeout:** hold `tx_busy` at 0 (no UART) with one byte queued → `tx_start` re-pulses every `START_TIMEOUT` + 2 cycles with the same byte, and `level` stays 0.
- **Simultaneous write and pop:** with `level` = 3, write in the same cycle as a pop → `level` stays 3 and the pointers wrap correctly past index DEPTH−1.
- **Reset mid-frame:** assert `rst_n` low during a frame with 5 bytes queued → all outputs take their reset values, the FIFO is empty, and no `tx_start` occurs until `tx_busy` is low and new data is written.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmit queue.
//   txq_state_t           - launch FSM state encoding
//   UART_DATA_W           - UART byte width
//   START_TIMEOUT_DEFAULT - default wait, in cycles, for the UART busy flag
//                           to rise after a launch pulse
package uart_pkg;

  localparam int UART_DATA_W           = 8;
  localparam int START_TIMEOUT_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } txq_state_t;

endpackage

// File: rtl/uart_tx_queue_if.sv
// uart_tx_queue_if: host-side and UART-side signals of the transmit queue.
//   wr_en / wr_data         host byte write strobe and data
//   full / empty / level    queue occupancy flags and entry count
//   tx_start / tx_data      launch pulse and held byte toward the UART
//   tx_busy                 UART busy flag back into the queue
//   idle                    launch FSM idle with nothing queued
//   overflow / overflow_clr sticky dropped-write flag and its clear
//                           (only with UART_TX_QUEUE_OVERFLOW_EN defined)
// Modports: master = host/UART side, slave = the queue.
interface uart_tx_queue_if
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
);

  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic                   wr_en;
  logic [UART_DATA_W-1:0] wr_data;
  logic                   full;
  logic                   empty;
  logic [LVL_W-1:0]       level;
  logic                   tx_start;
  logic [UART_DATA_W-1:0] tx_data;
  logic                   tx_busy;
  logic                   idle;
`ifdef UART_TX_QUEUE_OVERFLOW_EN
  logic                   overflow;
  logic                   overflow_clr;
`endif

  modport master (
    output wr_en, wr_data, tx_busy,
`ifdef UART_TX_QUEUE_OVERFLOW_EN
    output overflow_clr,
    input  overflow,
`endif
    input  full, empty, level, tx_start, tx_data, idle
  );

  modport slave (
    input  wr_en, wr_data, tx_busy,
`ifdef UART_TX_QUEUE_OVERFLOW_EN
    input  overflow_clr,
    output overflow,
`endif
    output full, empty, level, tx_start, tx_data, idle
  );

endinterface

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock circular FIFO with registered flags.
//   clk, rst_n      clock, asynchronous active-low reset
//   wr_en, wr_data  write request (ignored while full)
//   rd_en, rd_data  pop request (ignored while empty); rd_data is the head
//   full, empty     registered occupancy flags
//   level           registered entry count
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module uart_sync_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [LVL_W-1:0]  level_q;
  logic [LVL_W-1:0]  level_nxt;
  logic              full_q;
  logic              empty_q;
  logic              wr_ok;
  logic              rd_ok;

  // Acceptance uses the flags of the current state, so a write while full
  // is dropped even when a pop happens in the same cycle.
  assign wr_ok = wr_en & ~full_q;
  assign rd_ok = rd_en & ~empty_q;

  always_comb begin
    level_nxt = level_q;
    case ({wr_ok, rd_ok})
      2'b10:   level_nxt = level_q + LVL_W'(1);
      2'b01:   level_nxt = level_q - LVL_W'(1);
      default: level_nxt = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (rd_ok) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q <= level_nxt;
      full_q  <= (level_nxt == LVL_W'(DEPTH));
      empty_q <= (level_nxt == '0);
    end
  end

  // Storage carries no reset; only occupancy state is cleared.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem[rd_ptr_q];
  assign full    = full_q;
  assign empty   = empty_q;
  assign level   = level_q;

endmodule

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte queue feeding a UART transmitter.
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         uart_tx_queue_if.slave:
//                 wr_en/wr_data in, full/empty/level out,
//                 tx_start/tx_data out to UART start/i_data,
//                 tx_busy in from UART o_busy, idle out,
//                 overflow out / overflow_clr in with UART_TX_QUEUE_OVERFLOW_EN
// Optional feature macro: UART_TX_QUEUE_OVERFLOW_EN (sticky dropped-write flag).
// DEPTH must match the DEPTH of the connected interface instance.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int DEPTH         = 16,
  parameter int START_TIMEOUT = START_TIMEOUT_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_tx_queue_if.slave bus
);

  localparam int LVL_W = $clog2(DEPTH) + 1;

  txq_state_t             state_q;
  txq_state_t             state_nxt;
  logic [7:0]             cnt_q;
  logic [7:0]             cnt_nxt;
  logic                   start_q;
  logic                   start_nxt;
  logic [UART_DATA_W-1:0] data_q;
  logic [UART_DATA_W-1:0] head;
  logic                   pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [LVL_W-1:0]       fifo_level;

  uart_sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (UART_DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (bus.wr_en),
    .wr_data (bus.wr_data),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    start_nxt = 1'b0;
    pop       = 1'b0;
    case (state_q)
      // Launch only when the UART is free; after a reset mid-frame the
      // in-flight frame keeps tx_busy high and holds us here.
      IDLE: begin
        if (!fifo_empty && !bus.tx_busy) begin
          pop       = 1'b1;
          start_nxt = 1'b1;
          state_nxt = LAUNCH;
        end
      end
      LAUNCH: begin
        cnt_nxt   = '0;
        state_nxt = WAIT_BUSY;
      end
      // A UART that never raises busy gets the same byte re-launched,
      // without consuming another queue entry.
      WAIT_BUSY: begin
        if (bus.tx_busy) begin
          state_nxt = WAIT_DONE;
        end else if (cnt_q == 8'(START_TIMEOUT)) begin
          start_nxt = 1'b1;
          state_nxt = LAUNCH;
        end else begin
          cnt_nxt = cnt_q + 8'd1;
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      start_q <= start_nxt;
    end
  end

  // The launched byte is held until the next pop so it stays valid for
  // the whole UART frame, including re-launches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (pop) begin
      data_q <= head;
    end
  end

`ifdef UART_TX_QUEUE_OVERFLOW_EN
  logic ovf_q;

  // Set wins over clear when both happen in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (bus.wr_en && fifo_full) begin
      ovf_q <= 1'b1;
    end else if (bus.overflow_clr) begin
      ovf_q <= 1'b0;
    end
  end

  assign bus.overflow = ovf_q;
`else
  // Writes while full are dropped silently in this build.
`endif

  assign bus.full     = fifo_full;
  assign bus.empty    = fifo_empty;
  assign bus.level    = fifo_level;
  assign bus.tx_start = start_q;
  assign bus.tx_data  = data_q;
  assign bus.idle     = (state_q == IDLE) && fifo_empty;

endmodule

// File: tb/tb_uart_tx_queue.sv
// tb_uart_tx_queue: directed bench for uart_tx_queue with a behavioural
// UART loopback model (captures the byte at each launch it accepts and
// holds busy for a fixed frame length).
module tb_uart_tx_queue;

  localparam int DEPTH = 16;
  localparam int ST    = 8;
  localparam int FRAME = 12;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  uart_tx_queue_if #(.DEPTH(DEPTH)) bus ();

  uart_tx_queue #(
    .DEPTH         (DEPTH),
    .START_TIMEOUT (ST)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // UART model and monitors
  logic        uart_en    = 1'b1;
  logic        busy_force = 1'b0;
  logic        stab_en    = 1'b1;
  logic        uart_busy  = 1'b0;
  int unsigned frame_cnt  = 0;
  logic [7:0]  cur_byte   = 8'h00;
  logic [7:0]  rx_q [$];
  int unsigned pulses     = 0;
  logic        prev_start = 1'b0;
  logic        dbl        = 1'b0;
  logic        unstable   = 1'b0;

  assign bus.tx_busy = uart_en ? uart_busy : busy_force;

  always @(posedge clk) begin
    prev_start <= bus.tx_start;
    if (prev_start && bus.tx_start) dbl <= 1'b1;
    if (bus.tx_start) pulses <= pulses + 1;
    if (uart_busy) begin
      if (stab_en && (bus.tx_data !== cur_byte)) unstable <= 1'b1;
      if (frame_cnt == 0) uart_busy <= 1'b0;
      else                frame_cnt <= frame_cnt - 1;
    end else if (uart_en && bus.tx_start) begin
      uart_busy <= 1'b1;
      frame_cnt <= FRAME - 1;
      cur_byte  <= bus.tx_data;
      rx_q.push_back(bus.tx_data);
    end
  end

  int vectors     = 0;
  int miscompares = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n;
    n = 0;
    while (!(bus.idle === 1'b1 && bus.tx_busy === 1'b0) && n < budget) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, (bus.idle === 1'b1 && bus.tx_busy === 1'b0)}, 32'd1);
  endtask

  // One pop driven by toggling the busy line by hand; starts and ends in
  // IDLE with busy high.
  task automatic manual_pop(input logic do_wr, input logic [7:0] wd,
                            input logic [7:0] exp_byte, input int exp_level,
                            input string tag);
    busy_force  = 1'b0;
    bus.wr_en   = do_wr;
    bus.wr_data = wd;
    tick();
    bus.wr_en = 1'b0;
    chk({tag, "_start"}, bus.tx_start, 1);
    chk({tag, "_data"}, bus.tx_data, exp_byte);
    chk({tag, "_level"}, bus.level, exp_level);
    busy_force = 1'b1;
    tick();
    tick();
    busy_force = 1'b0;
    tick();
    busy_force = 1'b1;
    tick();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_full"},  bus.full, 0);
    chk({tag, "_empty"}, bus.empty, 1);
    chk({tag, "_level"}, bus.level, 0);
    chk({tag, "_start"}, bus.tx_start, 0);
    chk({tag, "_data"},  bus.tx_data, 0);
    chk({tag, "_idle"},  bus.idle, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned p0;
    int unsigned p1;
    int unsigned p2;
    int n;

    rst_n       = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
`ifdef UART_TX_QUEUE_OVERFLOW_EN
    bus.overflow_clr = 1'b0;
`endif
    repeat (3) tick();
    chk_reset_vals("reset");
`ifdef UART_TX_QUEUE_OVERFLOW_EN
    chk("reset_ovf", bus.overflow, 0);
`endif
    rst_n = 1'b1;
    tick();

    // Single byte: write at edge E, launch visible after E+1
    bus.wr_en = 1'b1; bus.wr_data = 8'hA5;
    tick();
    bus.wr_en = 1'b0;
    chk("single_lvl_E", bus.level, 1);
    chk("single_start_E", bus.tx_start, 0);
    tick();
    chk("single_start_E1", bus.tx_start, 1);
    chk("single_data_E1", bus.tx_data, 8'hA5);
    chk("single_lvl_E1", bus.level, 0);
    chk("single_empty_E1", bus.empty, 1);
    tick();
    chk("single_start_E2", bus.tx_start, 0);
    chk("single_data_E2", bus.tx_data, 8'hA5);
    wait_idle(100, "single_idle");
    chk("single_rx_n", rx_q.size(), 1);
    chk("single_rx0", rx_q[0], 8'hA5);
    chk("single_pulses", pulses, 1);

    // Burst of 16 with the UART held busy so nothing drains
    p0 = pulses;
    uart_en = 1'b0; busy_force = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'(i);
      tick();
      if (i == 15) begin
        chk("burst_full15", bus.full, 0);
        chk("burst_lvl15", bus.level, 15);
      end
    end
    bus.wr_en = 1'b0;
    chk("burst_lvl16", bus.level, 16);
    chk("burst_full16", bus.full, 1);
    chk("burst_empty16", bus.empty, 0);

    // Overflow: write while full is dropped
    bus.wr_en = 1'b1; bus.wr_data = 8'hFF;
    tick();
    bus.wr_en = 1'b0;
    chk("ovf_lvl", bus.level, 16);
    chk("ovf_full", bus.full, 1);
`ifdef UART_TX_QUEUE_OVERFLOW_EN
    chk("ovf_set", bus.overflow, 1);
    tick();
    chk("ovf_hold", bus.overflow, 1);
    bus.wr_en = 1'b1; bus.wr_data = 8'hFF; bus.overflow_clr = 1'b1;
    tick();
    bus.wr_en = 1'b0; bus.overflow_clr = 1'b0;
    chk("ovf_set_prio", bus.overflow, 1);
    bus.overflow_clr = 1'b1;
    tick();
    bus.overflow_clr = 1'b0;
    chk("ovf_clr", bus.overflow, 0);
`endif

    // Write while full in the same cycle as a pop: write still dropped
    uart_en = 1'b1;
    bus.wr_en = 1'b1; bus.wr_data = 8'hEE;
    tick();
    bus.wr_en = 1'b0;
    chk("droppop_lvl", bus.level, 15);
    chk("droppop_full", bus.full, 0);
    chk("droppop_start", bus.tx_start, 1);
    chk("droppop_data", bus.tx_data, 8'h01);
`ifdef UART_TX_QUEUE_OVERFLOW_EN
    chk("droppop_ovf", bus.overflow, 1);
`endif
    wait_idle(1000, "burst_idle");
    chk("burst_rx_n", rx_q.size(), 17);
    for (int i = 0; i < 16; i++) chk("burst_rx", rx_q[1 + i], 8'(i + 1));
    chk("burst_pulses", pulses - p0, 16);
    chk("burst_unstable", unstable, 0);

    // Start timeout: no UART response, same byte re-launched every ST+2
    uart_en = 1'b0; busy_force = 1'b0;
    p1 = pulses;
    bus.wr_en = 1'b1; bus.wr_data = 8'h5A;
    tick();
    bus.wr_en = 1'b0;
    tick();
    chk("to_start1", bus.tx_start, 1);
    chk("to_data1", bus.tx_data, 8'h5A);
    repeat (9) tick();
    chk("to_gap", bus.tx_start, 0);
    tick();
    chk("to_start2", bus.tx_start, 1);
    chk("to_data2", bus.tx_data, 8'h5A);
    chk("to_lvl2", bus.level, 0);
    repeat (10) tick();
    chk("to_start3", bus.tx_start, 1);
    chk("to_data3", bus.tx_data, 8'h5A);
    busy_force = 1'b1;
    tick();
    tick();
    busy_force = 1'b0;
    wait_idle(20, "to_idle");
    chk("to_pulses", pulses - p1, 3);
    chk("to_lvl_end", bus.level, 0);

    // Simultaneous write and pop at level 3 across the pointer wrap
    busy_force = 1'b1;
    for (int i = 0; i < 13; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'(8'h20 + i);
      tick();
    end
    bus.wr_en = 1'b0;
    chk("sim_lvl13", bus.level, 13);
    for (int k = 0; k < 10; k++) manual_pop(1'b0, 8'h00, 8'(8'h20 + k), 12 - k, "sim_pre");
    chk("sim_lvl3", bus.level, 3);
    manual_pop(1'b1, 8'h2D, 8'h2A, 3, "sim_wp0");
    manual_pop(1'b1, 8'h2E, 8'h2B, 3, "sim_wp1");
    manual_pop(1'b1, 8'h2F, 8'h2C, 3, "sim_wp2");
    manual_pop(1'b0, 8'h00, 8'h2D, 2, "sim_post0");
    manual_pop(1'b0, 8'h00, 8'h2E, 1, "sim_post1");
    manual_pop(1'b0, 8'h00, 8'h2F, 0, "sim_post2");
    busy_force = 1'b0;
    tick();
    chk("sim_idle", bus.idle, 1);

    // Reset mid-frame with 5 bytes queued
    chk("pre_rst_unstable", unstable, 0);
    stab_en = 1'b0;
    uart_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'(8'h61 + i);
      tick();
    end
    bus.wr_en = 1'b0;
    chk("rst_lvl5", bus.level, 5);
    chk("rst_busy", uart_busy, 1);
    p2 = pulses;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst_mid");
    tick();
    rst_n = 1'b1;
    bus.wr_en = 1'b1; bus.wr_data = 8'h77;
    tick();
    bus.wr_en = 1'b0;
    chk("rst_wr_lvl", bus.level, 1);
    n = 0;
    while (uart_busy === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("rst_busy_fell", uart_busy, 0);
    chk("rst_no_launch", pulses - p2, 0);
    chk("rst_start_held", bus.tx_start, 0);
    tick();
    chk("rst_launch", bus.tx_start, 1);
    chk("rst_launch_data", bus.tx_data, 8'h77);
    wait_idle(100, "rst_idle");
    chk("rst_rx_n", rx_q.size(), 19);
    chk("rst_rx_inflight", rx_q[17], 8'h61);
    chk("rst_rx_new", rx_q[18], 8'h77);
    chk("no_double_pulse", dbl, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
